// File: rtl/data_sram_responder_if.sv
// Request/response bundle for the CPU data-SRAM port: valid/ready request channel
// and valid/ready response channel.
interface data_sram_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_wstrb, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_wstrb, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data-SRAM port: one request at a time, response
// after LATENCY cycles. Define DSRAM_DBG_PORT_EN to add a combinational debug read port.
module data_sram_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    data_sram_responder_if.slave bus
`ifdef DSRAM_DBG_PORT_EN
    ,
    input  logic [AW-1:0]        dbg_addr,
    output logic [31:0]          dbg_rdata
`endif
);

    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $error("data_sram_responder: LATENCY must be in 1..15");
    end
    if ((AW < 1) || (AW > 29)) begin : g_bad_aw
        $error("data_sram_responder: AW must be in 1..29");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;

    logic        we_r;
    logic [3:0]  wstrb_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;

    logic        accept_s;
    logic        acc_en_s;
    logic        acc_we_s;
    logic [3:0]  acc_wstrb_s;
    logic [31:0] acc_addr_s;
    logic [31:0] acc_wdata_s;
    logic        acc_err_s;
    logic [AW-1:0] acc_idx_s;
    logic        resp_done_s;

    logic        req_ready_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;

    logic [31:0] mem_r [0:DEPTH-1];

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (|a[31:AW+2]);
    endfunction

    assign accept_s    = (state_r == ST_IDLE) && bus.req_valid;
    assign resp_done_s = (state_r == ST_RESP) && bus.resp_ready;

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; acc_en_s marks the edge that enters RESP and performs the access.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        acc_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_s  = ST_RESP;
                        acc_en_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s  = ST_RESP;
                    cnt_s    = 4'd0;
                    acc_en_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            wstrb_r <= 4'h0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            wstrb_r <= bus.req_wstrb;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end
    end

    // With LATENCY=1 the access happens on the accepting edge, so it uses the live request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_we_s    = bus.req_we;
            acc_wstrb_s = bus.req_wstrb;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
        end else begin
            acc_we_s    = we_r;
            acc_wstrb_s = wstrb_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign acc_err_s = addr_err(acc_addr_s);
    assign acc_idx_s = acc_addr_s[AW+1:2];

    // Storage array with byte-enable writes; deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (!rst && acc_en_s && acc_we_s && !acc_err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb_s[i]) begin
                    mem_r[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Registered handshake outputs and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            if (acc_en_s) begin
                resp_err_r   <= acc_err_s;
                resp_rdata_r <= (acc_we_s || acc_err_s) ? 32'h0000_0000 : mem_r[acc_idx_s];
            end else if (resp_done_s) begin
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;

`ifdef DSRAM_DBG_PORT_EN
    assign dbg_rdata = mem_r[dbg_addr];
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: vector table on a LATENCY=3 instance plus
// backpressure, mid-WAIT reset and back-to-back reads on a LATENCY=1 instance.
module tb_data_sram_responder;

    typedef struct {
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_sram_responder_if bus_a ();
    data_sram_responder_if bus_b ();

`ifdef DSRAM_DBG_PORT_EN
    logic [9:0]  dbg_addr_a;
    logic [31:0] dbg_rdata_a;
    logic [9:0]  dbg_addr_b;
    logic [31:0] dbg_rdata_b;
`endif

    data_sram_responder #(.AW(10), .LATENCY(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
`ifdef DSRAM_DBG_PORT_EN
        ,
        .dbg_addr  (dbg_addr_a),
        .dbg_rdata (dbg_rdata_a)
`endif
    );

    data_sram_responder #(.AW(10), .LATENCY(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
`ifdef DSRAM_DBG_PORT_EN
        ,
        .dbg_addr  (dbg_addr_b),
        .dbg_rdata (dbg_rdata_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic we, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_wstrb = s;
            bus_a.req_addr = a;  bus_a.req_wdata = d;
        end else begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_wstrb = s;
            bus_b.req_addr = a;  bus_b.req_wdata = d;
        end
    endtask

    function automatic logic get_rr(input int sel);
        return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction
    function automatic logic get_rv(input int sel);
        return (sel == 0) ? bus_a.resp_valid : bus_b.resp_valid;
    endfunction
    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 0) ? bus_a.resp_rdata : bus_b.resp_rdata;
    endfunction
    function automatic logic get_re(input int sel);
        return (sel == 0) ? bus_a.resp_err : bus_b.resp_err;
    endfunction

    // One full transaction with resp_ready held high; checks latency and payload.
    task automatic txn(input int sel, input vec_t v, input int lat, input string name);
        int k;
        @(negedge clk);
        set_req(sel, 1'b1, v.we, v.wstrb, v.addr, v.wdata);
        if (sel == 0) bus_a.resp_ready = 1'b1; else bus_b.resp_ready = 1'b1;
        k = 0;
        while (!get_rr(sel) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            checks++; errors++;
            $display("FAIL %s accept timeout", name);
        end
        @(posedge clk);
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        k = 0;
        while (!get_rv(sel) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check32({name, " latency"}, 32'(k + 1), 32'(lat));
        check32({name, " rdata"}, get_rd(sel), v.exp_rdata);
        check32({name, " err"}, {31'd0, get_re(sel)}, {31'd0, v.exp_err});
        check32({name, " req_ready in RESP"}, {31'd0, get_rr(sel)}, 32'd0);
        @(posedge clk);
    endtask

    initial begin
        vec_t vecs[18];
        vec_t v;
        int   k;
        int   pulses;

        checks = 0;
        errors = 0;
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 4'h5, 32'h0000_0004, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0004, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b1, 4'hA, 32'h0000_0FFC, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0000_0000, 32'h11FE_330D, 1'b0};
        vecs[15] = '{1'b1, 4'hF, 32'h0000_0008, 32'h0000_00AA, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b0, 4'h0, 32'h0000_0008, 32'h0000_0000, 32'h0000_00AA, 1'b0};
        vecs[17] = '{1'b0, 4'h0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_a.resp_ready = 1'b0;
        bus_b.resp_ready = 1'b0;
`ifdef DSRAM_DBG_PORT_EN
        dbg_addr_a = 10'd0;
        dbg_addr_b = 10'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check32("reset req_ready a", {31'd0, bus_a.req_ready}, 32'd1);
        check32("reset resp_valid a", {31'd0, bus_a.resp_valid}, 32'd0);
        check32("reset rdata a", bus_a.resp_rdata, 32'h0);
        check32("reset err a", {31'd0, bus_a.resp_err}, 32'd0);
        check32("reset req_ready b", {31'd0, bus_b.req_ready}, 32'd1);
        check32("reset resp_valid b", {31'd0, bus_b.resp_valid}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            txn(0, vecs[i], 3, $sformatf("vec%0d", i));
        end

`ifdef DSRAM_DBG_PORT_EN
        @(negedge clk);
        dbg_addr_a = 10'd4;
        #1;
        check32("dbg mem[4]", dbg_rdata_a, 32'hDEAD_BEEF);
        dbg_addr_a = 10'd1;
        #1;
        check32("dbg mem[1]", dbg_rdata_a, 32'h11BB_33DD);
`endif

        // Backpressure: response must hold while resp_ready stays low.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
        bus_a.resp_ready = 1'b0;
        check32("bp req_ready idle", {31'd0, bus_a.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        k = 0;
        while (!bus_a.resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check32("bp latency", 32'(k + 1), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check32("bp resp_valid", {31'd0, bus_a.resp_valid}, 32'd1);
            check32("bp rdata", bus_a.resp_rdata, 32'h11BB_33DD);
            check32("bp req_ready", {31'd0, bus_a.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus_a.resp_ready = 1'b1;
        @(negedge clk);
        check32("bp release resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
        check32("bp release req_ready", {31'd0, bus_a.req_ready}, 32'd1);

        // Reset one cycle after accepting a write: write dropped, no response.
        set_req(0, 1'b1, 1'b1, 4'hF, 32'h0000_0008, 32'h0000_0055);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check32("rst-wait resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
            check32("rst-wait req_ready", {31'd0, bus_a.req_ready}, 32'd1);
            @(negedge clk);
        end
        v = '{1'b0, 4'h0, 32'h0000_0008, 32'h0000_0000, 32'h0000_00AA, 1'b0};
        txn(0, v, 3, "rst-wait readback");

        // LATENCY=1 instance: single write, then back-to-back reads.
        v = '{1'b1, 4'hF, 32'h0000_0010, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
        txn(1, v, 1, "lat1 write");
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        bus_b.resp_ready = 1'b1;
        pulses = 0;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_b.resp_valid) pulses++;
            check32("b2b resp_valid", {31'd0, bus_b.resp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check32("b2b req_ready", {31'd0, bus_b.req_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) begin
                check32("b2b rdata", bus_b.resp_rdata, 32'h0BAD_F00D);
            end
            if (i == 7) begin
                set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end
        check32("b2b accepts in 8 cycles", 32'(pulses), 32'd4);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
